demultiplexer_reg: RTL

Registered 1-to-CHANNELS demultiplexer, the write-side counterpart of the ALU's M-channel select multiplexer. It steers one WIDTH-bit input word into the output lane chosen by a select code. Each lane holds its word in a single-entry register with valid/ack handshaking. The lanes are packed onto a flat bus in the same lane order the multiplexer reads (lane c at bits c*WIDTH +: WIDTH), so the two blocks can be wired back to back.

---
 rtl/demultiplexer_reg.sv | 99 +++++++++
 1 files changed

// File: rtl/demultiplexer_reg.sv
// demultiplexer_reg: registered 1-to-CHANNELS demultiplexer.
// Steers one WIDTH-bit word into the lane picked by in_sel_i. Each lane is a
// single-entry register with valid/ack handshaking. Lanes are packed onto
// out_bus_o with lane c at bits c*WIDTH +: WIDTH, the same order the matching
// select multiplexer reads them.
module demultiplexer_reg #(
  parameter int WIDTH      = 8,
  parameter int CHANNELS   = 4,
  parameter int SEL_LENGTH = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [WIDTH-1:0]          in_data_i,
  input  logic [SEL_LENGTH-1:0]     in_sel_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  output logic [CHANNELS*WIDTH-1:0] out_bus_o,
  output logic [CHANNELS-1:0]       out_valid_o,
  input  logic [CHANNELS-1:0]       out_ack_i,
  output logic                      err_sel_o
);

  // Lane count at select width plus one bit, so codes >= CHANNELS compare
  // correctly even when CHANNELS == 2**SEL_LENGTH.
  localparam logic [SEL_LENGTH:0] CHANNELS_L = CHANNELS[SEL_LENGTH:0];

  logic                sel_in_range;
  logic                accept;
  logic [CHANNELS-1:0] sel_hit;
  logic [CHANNELS-1:0] lane_free;
  logic [CHANNELS-1:0] lane_wr;
  logic [CHANNELS-1:0] valid_q;
  logic                err_q;
  logic                err_d;

  assign sel_in_range = ({1'b0, in_sel_i} < CHANNELS_L);

  // A lane can take a word when it is empty or is being drained this cycle.
  // Out-of-range codes are always taken so the producer never stalls on them.
  assign in_ready_o = !sel_in_range || |(sel_hit & lane_free);
  assign accept     = in_valid_i && in_ready_o;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi = gi + 1) begin : g_lane
      logic [WIDTH-1:0] data_q;
      logic [WIDTH-1:0] data_d;
      logic             valid_d;

      assign sel_hit[gi]   = (in_sel_i == SEL_LENGTH'(gi));
      assign lane_free[gi] = !valid_q[gi] || out_ack_i[gi];
      assign lane_wr[gi]   = accept && sel_hit[gi];

      // Next lane state: a write wins over an ack so a lane can stream one
      // word per cycle; an ack alone only clears valid and keeps the data.
      always_comb begin
        data_d  = data_q;
        valid_d = valid_q[gi];
        if (lane_wr[gi]) begin
          data_d  = in_data_i;
          valid_d = 1'b1;
        end else if (out_ack_i[gi]) begin
          valid_d = 1'b0;
        end
      end

      // Lane data and valid registers.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          data_q      <= '0;
          valid_q[gi] <= 1'b0;
        end else begin
          data_q      <= data_d;
          valid_q[gi] <= valid_d;
        end
      end

      assign out_bus_o[gi*WIDTH +: WIDTH] = data_q;
    end
  endgenerate

  // Sticky flag: set once any out-of-range word has been accepted.
  always_comb begin
    err_d = err_q || (accept && !sel_in_range);
  end

  // Error flag register, cleared only by reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign out_valid_o = valid_q;
  assign err_sel_o   = err_q;

endmodule
